rst_sequencer: RTL
==================

RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 Parameter CLK_FRE, default 50: clock frequency in MHz, integer, at least 1.
REQ-002 Parameter NUM_CH, default 4: number of reset domains sequenced, range 1..32.
REQ-003 Parameter HOLD_US, default 50000: initial hold time in microseconds before channel 0 is released.
REQ-004 Parameter STEP_US, default 100: spacing in microseconds between consecutive channel releases.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 lock  input  1  clock-source/PLL locked; sequence runs only while high.
REQ-008 soft_rst  input  1  synchronous request to re-run the full sequence; level-sensitive.
REQ-009 rstn_out  output  NUM_CH  per-domain reset, active-low; bit k feeds domain k.
REQ-010 seq_done  output  1  high when all channels are released.
REQ-011 stage  output  clog2(NUM_CH+1)  count of channels currently released, 0..NUM_CH.

Function
REQ-012 HOLD_CYC = CLK_FRE*HOLD_US and STEP_CYC = CLK_FRE*STEP_US, computed at elaboration; both SHALL be at least 1, else elaboration error.
REQ-013 The cycle counter width SHALL be clog2(max(HOLD_CYC,STEP_CYC)+1); counter never wraps.
REQ-014 States: IDLE, HOLD, RELEASE, DONE.
REQ-015 IDLE: rstn_out all 0, stage 0, seq_done 0; go to HOLD with cnt=0 on an edge sampling lock=1 and soft_rst=0 (edge E0).
REQ-016 HOLD: cnt increments each cycle; on the edge where cnt==HOLD_CYC-1, set rstn_out[0]=1, stage=1, cnt=0, go to RELEASE (or DONE if NUM_CH==1); ch0 rises at edge E0+HOLD_CYC.
REQ-017 RELEASE: cnt increments; on the edge where cnt==STEP_CYC-1, set rstn_out[stage]=1, stage+1, cnt=0; channel k rises at edge E0+HOLD_CYC+k*STEP_CYC.
REQ-018 The release of channel NUM_CH-1 SHALL move to DONE with seq_done=1 on the same edge.
REQ-019 Released channels SHALL stay released until abort; channels are released strictly in index order, one per step, never skipping.
REQ-020 Abort: lock=0 or soft_rst=1 sampled in any state SHALL, on that edge, clear rstn_out, stage, seq_done and cnt and enter IDLE; lock has no priority over soft_rst (either aborts).
REQ-021 While soft_rst or lock=0 persists, the block SHALL remain in IDLE; the sequence restarts from HOLD when the condition clears.
REQ-022 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, rstn_out=0, seq_done=0, stage=0, cnt=0, with priority over lock and soft_rst.
REQ-024 Reset asserted mid-sequence SHALL abort identically to REQ-020; no partial state is retained.

Structure
REQ-025 Package rst_seq_pkg SHALL hold the state enumeration and the clog2/max helper functions for counter widths.
REQ-026 One sub-module, rst_step_timer (load/enable/expire counter, width-parametrised), SHALL implement the HOLD/STEP counting; the FSM and channel register stay in rst_sequencer.

Verification
Bench parameters: CLK_FRE=1, HOLD_US=4, STEP_US=2, NUM_CH=3 (HOLD_CYC=4, STEP_CYC=2).
REQ-027 Release rst, lock=1 from E0 -> rstn_out 000 until E4, 001 at E4, 011 at E6, 111 and seq_done=1 at E8, stage 1/2/3.
REQ-028 lock=0 for one cycle after E6 -> rstn_out=000, stage=0 on that edge; after lock returns, new E0', ch0 at E0'+4.
REQ-029 soft_rst held 5 cycles while in DONE -> all outputs cleared on first edge, stay in IDLE 5 cycles, full sequence repeats with identical timing.
REQ-030 rst=1 at E5 with lock=1, soft_rst=1 simultaneously -> all outputs 0; after rst and soft_rst drop, sequence restarts from IDLE.
REQ-031 NUM_CH=1, HOLD_US=1 -> rstn_out[0] and seq_done both rise at E1.
REQ-032 lock held 0 from reset -> rstn_out stays 0, seq_done 0, stage 0 for at least 100 cycles.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and elaboration helpers for the reset sequencer.
package rst_seq_pkg;

  // Sequencer FSM states; the encoding is visible on the state_dbg port.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } seq_state_t;

  // Ceiling log2 for positive values up to 2**30; used to size counters.
  function automatic int clog2_ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Larger of two integers.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_step_timer.sv
// Cycle timer for the hold and step intervals: load clears, enable counts,
// expire flags the cycle on which the count equals the programmed last value.
// The owner reloads on expire, so the count never passes `last` and never wraps.
module rst_step_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         expire
);

  logic [W-1:0] cnt;

  assign expire = en && (cnt == last);

  // Count up while enabled; load (or reset) returns the count to zero.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Power-on reset sequencer: after lock is seen, waits HOLD_US and then
// releases the active-low domain resets one by one, STEP_US apart.
// Losing lock, a soft reset request or rst aborts to IDLE with every
// domain held in reset again. No handshakes: all inputs are levels.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int  CLK_FRE = 50,
  parameter int  NUM_CH  = 4,
  parameter int  HOLD_US = 50000,
  parameter int  STEP_US = 100,
  localparam int SW      = clog2_ceil(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lock,
  input  logic              soft_rst,
  output logic [NUM_CH-1:0] rstn_out,
  output logic              seq_done,
  output logic [SW-1:0]     stage,
  output logic [1:0]        state_dbg
);

  localparam int HOLD_CYC = CLK_FRE * HOLD_US;
  localparam int STEP_CYC = CLK_FRE * STEP_US;
  localparam int CW       = clog2_ceil(max_int(HOLD_CYC, STEP_CYC) + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYC - 1);

  if (HOLD_CYC < 1 || STEP_CYC < 1) begin : g_bad_timing
    $error("rst_sequencer: CLK_FRE*HOLD_US and CLK_FRE*STEP_US must both be at least 1");
  end
  if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
    $error("rst_sequencer: NUM_CH must be in 1..32");
  end

  seq_state_t        state;
  logic              abort;
  logic              tmr_load;
  logic              tmr_en;
  logic              tmr_expire;
  logic [CW-1:0]     tmr_last;
  logic              last_ch;
  logic [NUM_CH-1:0] next_bit;

  // Any of these sends the block back to IDLE on the edge that samples it.
  assign abort    = rst | ~lock | soft_rst;
  assign tmr_en   = (state == ST_HOLD) || (state == ST_RELEASE);
  // Keep the timer at zero while idle and restart it after every release.
  assign tmr_load = abort | (state == ST_IDLE) | tmr_expire;
  assign tmr_last = (state == ST_HOLD) ? HOLD_LAST : STEP_LAST;
  assign last_ch  = (stage == SW'(NUM_CH - 1));
  // Channels release in index order, so the next bit to set is the stage count.
  assign next_bit = NUM_CH'(1) << stage;

  assign state_dbg = state;

  rst_step_timer #(
    .W (CW)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .en     (tmr_en),
    .last   (tmr_last),
    .expire (tmr_expire)
  );

  // Sequencer FSM with registered reset outputs; abort beats every state.
  always_ff @(posedge clk) begin
    if (abort) begin
      state    <= ST_IDLE;
      rstn_out <= '0;
      stage    <= '0;
      seq_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (tmr_expire) begin
            rstn_out <= rstn_out | next_bit;
            stage    <= SW'(1);
            if (NUM_CH == 1) begin
              state    <= ST_DONE;
              seq_done <= 1'b1;
            end else begin
              state <= ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (tmr_expire) begin
            rstn_out <= rstn_out | next_bit;
            stage    <= stage + SW'(1);
            if (last_ch) begin
              state    <= ST_DONE;
              seq_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
